fib_checker: RTL

Synthesizable result monitor for the ALU/register-file datapath when it is driven by the Fibonacci control sequencer. It sits on the consumer side of the datapath, watching the ALU result bus and flags. It captures the two seed values and recomputes each following Fibonacci term internally, comparing every committed ALU result against it. It reports a running match count, a sticky pass/fail verdict and the index of the first mismatch, for use on the demo board and in benches.

---
 rtl/fib_pkg.sv | 23 ++
 rtl/fib_expect.sv | 78 +++++++
 rtl/fib_checker.sv | 119 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the Fibonacci result checker.
//   DATA_W        width of the ALU result bus
//   FLAG_*        bit positions within the ALU flags bus
//   state_t       checker FSM states
package fib_pkg;

  localparam int unsigned DATA_W = 16;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  typedef enum logic [2:0] {
    SEED0,
    SEED1,
    CHECK,
    DONE,
    FAIL
  } state_t;

endpackage

// File: rtl/fib_expect.sv
// fib_expect: next-term generator for the Fibonacci checker.
// Holds prev/curr/expected and a single 17-bit adder shared between seeding
// (prev + seed1) and advancing (curr + accepted result).
// Optional macro FIB_CHECKER_FLAGS_EN adds registered expected-carry and
// expected-zero outputs.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_load_prev      latch i_data as prev (first seed)
//   i_load_curr      latch i_data as curr, expected <= prev + i_data
//   i_advance        shift: prev <= curr, curr <= i_data, expected <= curr + i_data
//   i_data           ALU result being accepted
//   o_expected       registered next expected term
//   o_carry/o_zero   (FIB_CHECKER_FLAGS_EN only) expected carry / expected == 0
module fib_expect
  import fib_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_prev,
  input  logic              i_load_curr,
  input  logic              i_advance,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_expected
`ifdef FIB_CHECKER_FLAGS_EN
  ,
  output logic              o_carry,
  output logic              o_zero
`endif
);

  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_curr;
  logic [DATA_W-1:0] r_expected;
  logic [DATA_W-1:0] w_addend;
  logic [DATA_W:0]   w_sum;

  // While seeding, the new term is prev + second seed; afterwards curr + result.
  assign w_addend = i_load_curr ? r_prev : r_curr;
  assign w_sum    = {1'b0, w_addend} + {1'b0, i_data};

`ifdef FIB_CHECKER_FLAGS_EN
  logic r_carry;
  assign o_carry = r_carry;
  assign o_zero  = (r_expected == '0);
`else
  logic w_carry_unused;
  assign w_carry_unused = w_sum[DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= '0;
      r_curr     <= '0;
      r_expected <= '0;
`ifdef FIB_CHECKER_FLAGS_EN
      r_carry    <= 1'b0;
`endif
    end else if (i_load_prev) begin
      r_prev <= i_data;
    end else if (i_load_curr) begin
      r_curr     <= i_data;
      r_expected <= w_sum[DATA_W-1:0];
`ifdef FIB_CHECKER_FLAGS_EN
      r_carry    <= w_sum[DATA_W];
`endif
    end else if (i_advance) begin
      r_prev     <= r_curr;
      r_curr     <= i_data;
      r_expected <= w_sum[DATA_W-1:0];
`ifdef FIB_CHECKER_FLAGS_EN
      r_carry    <= w_sum[DATA_W];
`endif
    end
  end

  assign o_expected = r_expected;

endmodule

// File: rtl/fib_checker.sv
// fib_checker: result monitor for the Fibonacci-sequenced ALU datapath.
// Captures two seeds, then compares each committed ALU result against the
// internally generated next term, counting matches up to NUM_CHECKS.
// Optional macro FIB_CHECKER_FLAGS_EN: comparison also requires flags[C] to
// equal the expected carry and flags[Z] to equal (expected == 0).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   result_valid   one-cycle strobe: alu_bus/flags hold a committed result
//   alu_bus        ALU result
//   flags          ALU flags {N, Z, F, L, C}
//   expected       next expected term (registered)
//   match_count    matched results, saturates at NUM_CHECKS
//   fail_index     match_count at first mismatch
//   done           sticky pass verdict
//   fail           sticky fail verdict
module fib_checker
  import fib_pkg::*;
#(
  parameter int unsigned NUM_CHECKS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] alu_bus,
  input  logic [4:0]        flags,
  output logic [DATA_W-1:0] expected,
  output logic [7:0]        match_count,
  output logic [7:0]        fail_index,
  output logic              done,
  output logic              fail
);

  localparam logic [7:0] LP_LIMIT = 8'(NUM_CHECKS);

  state_t            r_state;
  logic [7:0]        r_match_count;
  logic [7:0]        r_fail_index;
  logic              r_done;
  logic              r_fail;

  logic [DATA_W-1:0] w_expected;
  logic [7:0]        w_count_next;
  logic              w_match;
  logic              w_load_prev;
  logic              w_load_curr;
  logic              w_advance;

  assign w_count_next = r_match_count + 8'd1;

`ifdef FIB_CHECKER_FLAGS_EN
  logic w_exp_carry;
  logic w_exp_zero;
  assign w_match = (alu_bus == w_expected) &&
                   (flags[FLAG_C] == w_exp_carry) &&
                   (flags[FLAG_Z] == w_exp_zero);
`else
  logic w_flags_unused;
  assign w_flags_unused = ^flags;
  assign w_match        = (alu_bus == w_expected);
`endif

  assign w_load_prev = result_valid && (r_state == SEED0);
  assign w_load_curr = result_valid && (r_state == SEED1);
  // A mismatch must not advance the generator so expected stays frozen.
  assign w_advance   = result_valid && (r_state == CHECK) && w_match;

  fib_expect u_expect (
    .clk         (clk),
    .reset       (reset),
    .i_load_prev (w_load_prev),
    .i_load_curr (w_load_curr),
    .i_advance   (w_advance),
    .i_data      (alu_bus),
    .o_expected  (w_expected)
`ifdef FIB_CHECKER_FLAGS_EN
    ,
    .o_carry     (w_exp_carry),
    .o_zero      (w_exp_zero)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SEED0;
      r_match_count <= '0;
      r_fail_index  <= '0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
    end else if (result_valid) begin
      case (r_state)
        SEED0: r_state <= SEED1;
        SEED1: r_state <= CHECK;
        CHECK: begin
          if (w_match) begin
            r_match_count <= w_count_next;
            if (w_count_next == LP_LIMIT) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_fail_index <= r_match_count;
            r_fail       <= 1'b1;
            r_state      <= FAIL;
          end
        end
        DONE:    r_state <= DONE;
        FAIL:    r_state <= FAIL;
        default: r_state <= SEED0;
      endcase
    end
  end

  assign expected    = w_expected;
  assign match_count = r_match_count;
  assign fail_index  = r_fail_index;
  assign done        = r_done;
  assign fail        = r_fail;

endmodule
